// File: rtl/mult_div_pkg.sv
// ----------------------------------------------------------------------------
// mult_div_pkg
//   Shared definitions for the multicycle MULT/DIV responder and the control
//   unit that drives it.
//   - DEFAULT_WIDTH : operand width used by the CPU datapath
//   - OP_MULT/OP_DIV: meaning of the MultOrDiv request bit
//   - state_t       : FSM state encoding of mult_div_unit
// ----------------------------------------------------------------------------
package mult_div_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_MULT   = 3'd1,
        ST_DIV    = 3'd2,
        ST_DZERO  = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

endpackage

// File: rtl/mult_div_unit_div_step.sv
// ----------------------------------------------------------------------------
// div_step
//   One combinational restoring-division step on unsigned magnitudes.
//   The partial remainder and the remaining dividend bits are shifted left
//   together; the divisor is subtracted when it fits, and the quotient bit
//   enters at the bottom of the dividend register.
// Ports
//   i_rem     in  WIDTH  partial remainder (always < i_divisor)
//   i_quo     in  WIDTH  dividend bits still to consume / quotient so far
//   i_divisor in  WIDTH  divisor magnitude (non-zero)
//   o_rem     out WIDTH  updated partial remainder
//   o_quo     out WIDTH  updated dividend/quotient register
// ----------------------------------------------------------------------------
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_quo
);

    // One extra bit so the shifted remainder can never wrap before the compare.
    logic [WIDTH:0] w_rem_shift;
    logic           w_fits;

    always_comb begin
        w_rem_shift = {i_rem, i_quo[WIDTH-1]};
        w_fits      = (w_rem_shift >= {1'b0, i_divisor});
        o_rem       = w_rem_shift[WIDTH-1:0];
        o_quo       = {i_quo[WIDTH-2:0], 1'b0};
        if (w_fits) begin
            // Result is below the divisor, so it always fits in WIDTH bits.
            o_rem = WIDTH'(w_rem_shift - {1'b0, i_divisor});
            o_quo = {i_quo[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// ----------------------------------------------------------------------------
// mult_div_unit
//   Multicycle signed multiplier / divider for the MIPS-subset CPU.
//   MULT: radix-2 Booth, WIDTH iterations. DIV: restoring division on
//   magnitudes, WIDTH iterations, sign fix applied when the result is
//   registered. Divide-by-zero completes after one cycle with ErroDiv.
// Ports
//   clk        in   1      system clock
//   reset      in   1      synchronous active-high reset
//   start      in   1      operation request, sampled only in IDLE
//   MultOrDiv  in   1      OP_MULT / OP_DIV, sampled with start
//   A, B       in   WIDTH  signed operands, latched with start
//   HiOut      out  WIDTH  product high word / remainder
//   LoOut      out  WIDTH  product low word / quotient
//   busy       out  1      operation in progress
//   done       out  1      one-cycle completion pulse
//   ErroDiv    out  1      one-cycle pulse with done on divide-by-zero
// ----------------------------------------------------------------------------
module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             MultOrDiv,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] HiOut,
    output logic [WIDTH-1:0] LoOut,
    output logic             busy,
    output logic             done,
    output logic             ErroDiv
);

    state_t r_state;
    state_t w_state_next;

    logic [CNT_W-1:0] r_cnt;
    logic             r_op;
    // Booth: {r_acc, r_q, r_qm1}. r_acc carries one guard bit so that
    // subtracting the most negative multiplicand cannot overflow.
    // DIV reuses r_acc[WIDTH-1:0] as remainder and r_q as dividend/quotient.
    logic [WIDTH:0]   r_acc;
    logic [WIDTH-1:0] r_q;
    logic             r_qm1;
    logic [WIDTH-1:0] r_m;      // multiplicand or divisor magnitude
    logic             r_neg_q;
    logic             r_neg_r;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_done;
    logic             r_err;

    logic             w_last;
    logic [WIDTH:0]   w_booth_sum;
    logic [WIDTH:0]   w_acc_shift;
    logic [WIDTH-1:0] w_q_shift;
    logic             w_qm1_shift;
    logic [WIDTH-1:0] w_rem_step;
    logic [WIDTH-1:0] w_quo_step;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;

    assign w_last  = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_abs_a = A[WIDTH-1] ? (~A + 1'b1) : A;
    assign w_abs_b = B[WIDTH-1] ? (~B + 1'b1) : B;

    // Booth recode of the current multiplier bit pair, then arithmetic shift.
    always_comb begin
        w_booth_sum = r_acc;
        case ({r_q[0], r_qm1})
            2'b01:   w_booth_sum = r_acc + {r_m[WIDTH-1], r_m};
            2'b10:   w_booth_sum = r_acc - {r_m[WIDTH-1], r_m};
            default: w_booth_sum = r_acc;
        endcase
        {w_acc_shift, w_q_shift, w_qm1_shift} = {w_booth_sum[WIDTH], w_booth_sum, r_q};
    end

    div_step #(
        .WIDTH(WIDTH)
    ) u_div_step (
        .i_rem    (r_acc[WIDTH-1:0]),
        .i_quo    (r_q),
        .i_divisor(r_m),
        .o_rem    (w_rem_step),
        .o_quo    (w_quo_step)
    );

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (MultOrDiv == OP_MULT) begin
                        w_state_next = ST_MULT;
                    end else if (B == '0) begin
                        w_state_next = ST_DZERO;
                    end else begin
                        w_state_next = ST_DIV;
                    end
                end
            end
            ST_MULT, ST_DIV: begin
                if (w_last) begin
                    w_state_next = ST_FINISH;
                end
            end
            ST_DZERO, ST_FINISH: w_state_next = ST_IDLE;
            default:             w_state_next = ST_IDLE;
        endcase
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= '0;
            r_op    <= OP_MULT;
            r_acc   <= '0;
            r_q     <= '0;
            r_qm1   <= 1'b0;
            r_m     <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_op    <= MultOrDiv;
                        r_cnt   <= '0;
                        r_acc   <= '0;
                        r_qm1   <= 1'b0;
                        r_neg_q <= A[WIDTH-1] ^ B[WIDTH-1];
                        r_neg_r <= A[WIDTH-1];
                        if (MultOrDiv == OP_MULT) begin
                            r_q <= A;
                            r_m <= B;
                        end else begin
                            r_q <= w_abs_a;
                            r_m <= w_abs_b;
                        end
                    end
                end
                ST_MULT: begin
                    r_acc <= w_acc_shift;
                    r_q   <= w_q_shift;
                    r_qm1 <= w_qm1_shift;
                    r_cnt <= r_cnt + 1'b1;
                end
                ST_DIV: begin
                    r_acc <= {1'b0, w_rem_step};
                    r_q   <= w_quo_step;
                    r_cnt <= r_cnt + 1'b1;
                end
                ST_DZERO: begin
                    // Results are left untouched; only the error is reported.
                    r_done <= 1'b1;
                    r_err  <= 1'b1;
                end
                ST_FINISH: begin
                    r_done <= 1'b1;
                    if (r_op == OP_MULT) begin
                        r_hi <= r_acc[WIDTH-1:0];
                        r_lo <= r_q;
                    end else begin
                        // Truncation toward zero: remainder follows dividend sign.
                        r_lo <= r_neg_q ? (~r_q + 1'b1) : r_q;
                        r_hi <= r_neg_r ? (~r_acc[WIDTH-1:0] + 1'b1) : r_acc[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign HiOut   = r_hi;
    assign LoOut   = r_lo;
    assign done    = r_done;
    assign ErroDiv = r_err;

endmodule

// File: tb/tb_mult_div_unit.sv
// ----------------------------------------------------------------------------
// tb_mult_div_unit
//   Self-checking bench for mult_div_unit: directed scenarios plus randomized
//   signed operations compared against a plain-arithmetic reference model.
// ----------------------------------------------------------------------------
module tb_mult_div_unit;
    import mult_div_pkg::*;

    localparam int W   = 32;
    localparam int LAT = W + 1;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         MultOrDiv;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [W-1:0] HiOut;
    logic [W-1:0] LoOut;
    logic         busy;
    logic         done;
    logic         ErroDiv;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mult_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .MultOrDiv(MultOrDiv),
        .A        (A),
        .B        (B),
        .HiOut    (HiOut),
        .LoOut    (LoOut),
        .busy     (busy),
        .done     (done),
        .ErroDiv  (ErroDiv)
    );

    // Reference model: signed 64-bit arithmetic, division truncates toward zero.
    task automatic ref_model(input logic [31:0] a, input logic [31:0] b, input logic op,
                             input logic [31:0] prev_hi, input logic [31:0] prev_lo,
                             output logic [31:0] hi, output logic [31:0] lo, output logic err);
        longint sa, sb, p, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        err = 1'b0;
        if (op == OP_MULT) begin
            p  = sa * sb;
            hi = p[63:32];
            lo = p[31:0];
        end else if (b == 32'd0) begin
            hi  = prev_hi;
            lo  = prev_lo;
            err = 1'b1;
        end else begin
            q  = sa / sb;
            r  = sa % sb;
            lo = q[31:0];
            hi = r[31:0];
        end
    endtask

    // Issues one request and waits (bounded) for done. Operand inputs are
    // scrambled after the request edge; optionally start is re-pulsed.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic op,
                          input int repulse_at,
                          output int lat, output logic [31:0] hi, output logic [31:0] lo,
                          output logic err, output logic busy_k, output logic busy_gap,
                          output logic busy_at_done, output logic done_after);
        @(negedge clk);
        A = a; B = b; MultOrDiv = op; start = 1'b1;
        @(posedge clk);
        #1 busy_k = busy;
        busy_gap = 1'b0;
        lat = 0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            start = (c == repulse_at);
            A = $urandom;
            B = $urandom;
            if (c == repulse_at) MultOrDiv = ~op;
            @(posedge clk);
            #1;
            if (done) begin
                lat = c;
                break;
            end
            if (!busy || ErroDiv) busy_gap = 1'b1;
        end
        hi = HiOut;
        lo = LoOut;
        err = ErroDiv;
        busy_at_done = busy;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1 done_after = done | ErroDiv;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; MultOrDiv = OP_MULT; A = '0; B = '0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({busy, done, ErroDiv, HiOut, LoOut} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b done=%b err=%b hi=%h lo=%h, required all zero",
                     busy, done, ErroDiv, HiOut, LoOut);
        end
        @(negedge clk) reset = 1'b0;
    endtask

    task automatic test_mult_basic();
        int lat; logic [31:0] hi, lo; logic err, bk, bg, bd, da;
        run_op(32'd7, 32'hFFFFFFFD, OP_MULT, 0, lat, hi, lo, err, bk, bg, bd, da);
        $display("mult 7*-3: lat=%0d hi=%h lo=%h err=%b", lat, hi, lo, err);
        n_cmp++;
        if (lat !== LAT) begin n_fail++; $display("FAIL mult_latency: got %0d required %0d", lat, LAT); end
        n_cmp++;
        if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFEB) begin
            n_fail++; $display("FAIL mult_7x-3: got %h_%h required FFFFFFFF_FFFFFFEB", hi, lo);
        end
        n_cmp++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL mult_err: got %b required 0", err); end
        n_cmp++;
        if ({bk, bg, bd, da} !== 4'b1000) begin
            n_fail++; $display("FAIL mult_busy_done: busy_k=%b gap=%b busy_at_done=%b done_after=%b required 1000",
                               bk, bg, bd, da);
        end
    endtask

    task automatic test_mult_extremes();
        logic [31:0] va [2] = '{32'h7FFFFFFF, 32'h80000000};
        logic [63:0] ve [2] = '{64'h3FFFFFFF_00000001, 64'h40000000_00000000};
        int lat; logic [31:0] hi, lo; logic err, bk, bg, bd, da;
        for (int i = 0; i < 2; i++) begin
            run_op(va[i], va[i], OP_MULT, 0, lat, hi, lo, err, bk, bg, bd, da);
            $display("mult %h*%h: lat=%0d hi=%h lo=%h", va[i], va[i], lat, hi, lo);
            n_cmp++;
            if ({hi, lo} !== ve[i] || lat !== LAT || err !== 1'b0) begin
                n_fail++;
                $display("FAIL mult_extreme_%0d: got %h_%h lat=%0d err=%b required %h lat=%0d err=0",
                         i, hi, lo, lat, err, ve[i], LAT);
            end
        end
    endtask

    task automatic test_div_basic();
        logic [31:0] va [3] = '{32'hFFFFFFF9, 32'h80000000, 32'd100};
        logic [31:0] vb [3] = '{32'd2, 32'hFFFFFFFF, 32'd7};
        logic [63:0] ve [3] = '{64'hFFFFFFFF_FFFFFFFD, 64'h00000000_80000000, 64'h00000002_0000000E};
        int lat; logic [31:0] hi, lo; logic err, bk, bg, bd, da;
        for (int i = 0; i < 3; i++) begin
            run_op(va[i], vb[i], OP_DIV, 0, lat, hi, lo, err, bk, bg, bd, da);
            $display("div %h/%h: lat=%0d hi=%h lo=%h err=%b", va[i], vb[i], lat, hi, lo, err);
            n_cmp++;
            if ({hi, lo} !== ve[i] || lat !== LAT || err !== 1'b0 || {bk, bg, bd, da} !== 4'b1000) begin
                n_fail++;
                $display("FAIL div_%0d: got %h_%h lat=%0d err=%b flags=%b%b%b%b required %h lat=%0d err=0 flags=1000",
                         i, hi, lo, lat, err, bk, bg, bd, da, ve[i], LAT);
            end
        end
    endtask

    task automatic test_div_zero();
        int lat; logic [31:0] hi, lo; logic err, bk, bg, bd, da;
        run_op(32'd7, 32'hFFFFFFFD, OP_MULT, 0, lat, hi, lo, err, bk, bg, bd, da);
        run_op(32'd5, 32'd0, OP_DIV, 0, lat, hi, lo, err, bk, bg, bd, da);
        $display("div 5/0: lat=%0d hi=%h lo=%h err=%b busy=%b", lat, hi, lo, err, bd);
        n_cmp++;
        if (lat !== 1 || err !== 1'b1) begin
            n_fail++; $display("FAIL divzero_pulse: lat=%0d err=%b required lat=1 err=1", lat, err);
        end
        n_cmp++;
        if ({bk, bd, da} !== 3'b100) begin
            n_fail++; $display("FAIL divzero_busy: busy_k=%b busy_at_done=%b done_after=%b required 100", bk, bd, da);
        end
        n_cmp++;
        if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFEB) begin
            n_fail++; $display("FAIL divzero_hold: got %h_%h required FFFFFFFF_FFFFFFEB", hi, lo);
        end
    endtask

    task automatic test_reset_midop();
        logic saw_done;
        int lat; logic [31:0] hi, lo; logic err, bk, bg, bd, da;
        @(negedge clk);
        A = 32'd7; B = 32'hFFFFFFFD; MultOrDiv = OP_MULT; start = 1'b1;
        @(posedge clk);
        @(negedge clk) start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;
        $display("reset mid-op: busy=%b done=%b hi=%h lo=%h", busy, done, HiOut, LoOut);
        n_cmp++;
        if ({busy, done, ErroDiv, HiOut, LoOut} !== '0) begin
            n_fail++;
            $display("FAIL midop_reset: busy=%b done=%b err=%b hi=%h lo=%h required all zero",
                     busy, done, ErroDiv, HiOut, LoOut);
        end
        @(negedge clk) reset = 1'b0;
        saw_done = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1 if (done || busy) saw_done = 1'b1;
        end
        n_cmp++;
        if (saw_done !== 1'b0) begin n_fail++; $display("FAIL midop_abandon: done/busy seen=%b required 0", saw_done); end
        run_op(32'd100, 32'd7, OP_DIV, 0, lat, hi, lo, err, bk, bg, bd, da);
        $display("div 100/7 after reset: lat=%0d hi=%h lo=%h", lat, hi, lo);
        n_cmp++;
        if ({hi, lo} !== 64'h00000002_0000000E || lat !== LAT) begin
            n_fail++; $display("FAIL post_reset_div: got %h_%h lat=%0d required 00000002_0000000E lat=%0d", hi, lo, lat, LAT);
        end
    endtask

    task automatic test_ignore_restart();
        int lat; logic [31:0] hi, lo; logic err, bk, bg, bd, da;
        run_op(32'd7, 32'hFFFFFFFD, OP_MULT, 5, lat, hi, lo, err, bk, bg, bd, da);
        $display("mult with re-pulse: lat=%0d hi=%h lo=%h", lat, hi, lo);
        n_cmp++;
        if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFEB || lat !== LAT || bg !== 1'b0) begin
            n_fail++; $display("FAIL restart_mult: got %h_%h lat=%0d gap=%b required FFFFFFFF_FFFFFFEB lat=%0d gap=0",
                               hi, lo, lat, bg, LAT);
        end
        run_op(32'hFFFFFFF9, 32'd2, OP_DIV, 33, lat, hi, lo, err, bk, bg, bd, da);
        $display("div with re-pulse in finish: lat=%0d hi=%h lo=%h da=%b", lat, hi, lo, da);
        n_cmp++;
        if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFFD || lat !== LAT) begin
            n_fail++; $display("FAIL restart_div: got %h_%h lat=%0d required FFFFFFFF_FFFFFFFD lat=%0d", hi, lo, lat, LAT);
        end
    endtask

    task automatic test_back_to_back();
        int first, second;
        logic [31:0] eh, el; logic ee;
        logic [31:0] hi, lo;
        first = 0; second = 0; hi = '0; lo = '0;
        ref_model(32'd12345, 32'hFFFFFD4A, OP_MULT, 32'd0, 32'd0, eh, el, ee);
        @(negedge clk);
        A = 32'd12345; B = 32'hFFFFFD4A; MultOrDiv = OP_MULT; start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 120; c++) begin
            @(posedge clk);
            #1;
            if (done) begin
                if (first == 0) first = c;
                else begin
                    second = c; hi = HiOut; lo = LoOut;
                    break;
                end
            end
        end
        @(negedge clk) start = 1'b0;
        $display("back-to-back: first=%0d second=%0d hi=%h lo=%h", first, second, hi, lo);
        n_cmp++;
        if (first !== LAT || second !== 2 * LAT + 1) begin
            n_fail++; $display("FAIL b2b_timing: first=%0d second=%0d required %0d %0d", first, second, LAT, 2 * LAT + 1);
        end
        n_cmp++;
        if ({hi, lo} !== {eh, el}) begin
            n_fail++; $display("FAIL b2b_result: got %h_%h required %h_%h", hi, lo, eh, el);
        end
        repeat (3) @(posedge clk);
    endtask

    task automatic test_random();
        logic [31:0] ext [5] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
        logic [31:0] a, b, eh, el, mdl_hi, mdl_lo, hi, lo;
        logic op, ee, err, bk, bg, bd, da;
        int lat, exp_lat, rp, sel;
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        @(negedge clk) reset = 1'b0;
        mdl_hi = '0; mdl_lo = '0;
        for (int n = 0; n < 1000; n++) begin
            sel = $urandom_range(0, 9);
            a = (sel < 5) ? ext[sel] : $urandom;
            sel = $urandom_range(0, 9);
            b = (sel < 5) ? ext[sel] : $urandom;
            op = 1'($urandom_range(0, 1));
            rp = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 33) : 0;
            ref_model(a, b, op, mdl_hi, mdl_lo, eh, el, ee);
            exp_lat = ee ? 1 : LAT;
            run_op(a, b, op, rp, lat, hi, lo, err, bk, bg, bd, da);
            $display("rand %0d: op=%b a=%h b=%h lat=%0d hi=%h lo=%h err=%b", n, op, a, b, lat, hi, lo, err);
            n_cmp++;
            if (hi !== eh || lo !== el || err !== ee || lat !== exp_lat ||
                bk !== 1'b1 || bg !== 1'b0 || bd !== 1'b0 || da !== 1'b0) begin
                n_fail++;
                $display("FAIL rand_%0d: op=%b a=%h b=%h got hi=%h lo=%h err=%b lat=%0d flags=%b%b%b%b required hi=%h lo=%h err=%b lat=%0d flags=1000",
                         n, op, a, b, hi, lo, err, lat, bk, bg, bd, da, eh, el, ee, exp_lat);
            end
            mdl_hi = eh;
            mdl_lo = el;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_mult_basic();
        test_mult_extremes();
        test_div_basic();
        test_div_zero();
        test_reset_midop();
        test_ignore_restart();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
